// File: rtl/pio_rx_fifo_pkg.sv
// Shared types and helpers for the PIO RX/TX FIFO paths: data width,
// autopush threshold decode, push outcome and stall state encodings.
package pio_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        PUSH_NONE,
        PUSH_WRITE,
        PUSH_STALL,
        PUSH_DROP
    } push_outcome_e;

    typedef enum logic {
        IDLE,
        STALLED
    } rx_state_e;

    // A programmed threshold of 0 stands for a full 32-bit ISR.
    function automatic logic [5:0] thresh_decode(input logic [4:0] thresh);
        return (thresh == 5'd0) ? 6'd32 : {1'b0, thresh};
    endfunction

endpackage

// File: rtl/pio_rx_fifo_if.sv
// Host read port of the RX FIFO: valid/ready data, occupancy and sticky flags.
interface pio_rx_fifo_if #(parameter int WIDTH = pio_pkg::WIDTH);

    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [3:0]       level;
    logic             full;
    logic             rx_stall_flag;
    logic             rx_under_flag;
    logic [1:0]       flag_clr;

    modport master (
        input  rd_data, rd_valid, level, full, rx_stall_flag, rx_under_flag,
        output rd_ready, flag_clr
    );

    modport slave (
        output rd_data, rd_valid, level, full, rx_stall_flag, rx_under_flag,
        input  rd_ready, flag_clr
    );

endinterface

// File: rtl/pio_sync_fifo.sv
// Synchronous FIFO with run-time capacity (cap <= DEPTH) and a registered head
// output; shared by the PIO RX and TX paths.
module pio_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int LVL_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [LVL_W-1:0] cap,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr_reg, wptr_next;
    logic [PW-1:0]    rptr_reg, rptr_next;
    logic [LVL_W-1:0] level_reg, level_next;
    logic [WIDTH-1:0] rd_data_reg, rd_data_next;
    logic             wr_ok, rd_ok;

    // Pointers wrap at the active capacity, not at the storage size.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p, input logic [LVL_W-1:0] c);
        logic [LVL_W-1:0] n;
        n = LVL_W'(p) + LVL_W'(1);
        return (n == c) ? '0 : PW'(n);
    endfunction

    assign full    = (level_reg == cap);
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign rd_data = rd_data_reg;

    always_comb begin
        wr_ok      = wr_en && !full;
        rd_ok      = rd_en && !empty;
        wptr_next  = wr_ok ? ptr_inc(wptr_reg, cap) : wptr_reg;
        rptr_next  = rd_ok ? ptr_inc(rptr_reg, cap) : rptr_reg;
        level_next = level_reg + LVL_W'(wr_ok) - LVL_W'(rd_ok);
        // The next head is the incoming word when it lands on the slot being exposed.
        if (wr_ok && (wptr_reg == rptr_next)) begin
            rd_data_next = wr_data;
        end else begin
            rd_data_next = mem[rptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            level_reg   <= '0;
            rd_data_reg <= '0;
        end else if (flush) begin
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            level_reg   <= '0;
            rd_data_reg <= '0;
        end else begin
            wptr_reg    <= wptr_next;
            rptr_reg    <= rptr_next;
            level_reg   <= level_next;
            rd_data_reg <= rd_data_next;
        end
    end

endmodule

// File: rtl/pio_rx_fifo.sv
// PIO state-machine RX path: PUSH/autopush arbitration, ISR clear, full-FIFO
// stall and sticky flags. Define PIO_RX_FIFO_JOIN_EN for the fjoin_rx double-depth mode.
module pio_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = pio_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             penable,
    input  logic [WIDTH-1:0] isr_data,
    input  logic [5:0]       isr_count,
    input  logic             push_req,
    input  logic             push_iffull,
    input  logic             push_block,
    input  logic             autopush_en,
    input  logic [4:0]       push_thresh,
`ifdef PIO_RX_FIFO_JOIN_EN
    input  logic             fjoin_rx,
`endif
    output logic             isr_clear,
    output logic             push_stall,
    pio_rx_fifo_if.slave     bus
);

    import pio_pkg::*;

    localparam int LVL_W = 4;

`ifdef PIO_RX_FIFO_JOIN_EN
    localparam int STORE = 2 * DEPTH;
    logic             fjoin_reg;
    logic             flush;
    logic [LVL_W-1:0] cap;

    // Any change of the join mode discards the current contents.
    assign flush = fjoin_rx ^ fjoin_reg;
    assign cap   = fjoin_rx ? LVL_W'(2 * DEPTH) : LVL_W'(DEPTH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fjoin_reg <= 1'b0;
        end else begin
            fjoin_reg <= fjoin_rx;
        end
    end
`else
    localparam int STORE = DEPTH;
    logic             flush;
    logic [LVL_W-1:0] cap;

    assign flush = 1'b0;
    assign cap   = LVL_W'(DEPTH);
`endif

    logic          thresh_hit;
    logic          auto_push, expl_push, push_any;
    logic          fifo_full, fifo_empty;
    logic          wr_en, pop;
    logic          stall_raw;
    logic          stall_flag_reg, under_flag_reg;
    push_outcome_e outcome;
    rx_state_e     state_reg, state_next;

    assign thresh_hit = (isr_count >= thresh_decode(push_thresh));
    assign auto_push  = penable && autopush_en && thresh_hit;
    assign expl_push  = penable && !auto_push && push_req && !(push_iffull && !thresh_hit);
    assign push_any   = auto_push || expl_push;

    // Full is judged on pre-pop occupancy, so a same-cycle pop never makes room.
    always_comb begin
        outcome = PUSH_NONE;
        if (push_any) begin
            if (!fifo_full) begin
                outcome = PUSH_WRITE;
            end else if (auto_push || push_block) begin
                outcome = PUSH_STALL;
            end else begin
                outcome = PUSH_DROP;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        stall_raw  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (outcome == PUSH_STALL) begin
                    state_next = STALLED;
                    stall_raw  = 1'b1;
                end
            end
            STALLED: begin
                if (outcome == PUSH_STALL) begin
                    stall_raw = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            stall_flag_reg <= 1'b0;
            under_flag_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (bus.flag_clr[0]) begin
                stall_flag_reg <= 1'b0;
            end else if ((outcome == PUSH_STALL) || (outcome == PUSH_DROP)) begin
                stall_flag_reg <= 1'b1;
            end
            if (bus.flag_clr[1]) begin
                under_flag_reg <= 1'b0;
            end else if (bus.rd_ready && fifo_empty) begin
                under_flag_reg <= 1'b1;
            end
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign isr_clear  = reset_n && ((outcome == PUSH_WRITE) || (outcome == PUSH_DROP));
    assign push_stall = reset_n && stall_raw;
    assign wr_en      = (outcome == PUSH_WRITE);
    assign pop        = bus.rd_ready && !fifo_empty;

    assign bus.rd_valid      = !fifo_empty;
    assign bus.full          = fifo_full;
    assign bus.rx_stall_flag = stall_flag_reg;
    assign bus.rx_under_flag = under_flag_reg;

    pio_sync_fifo #(
        .DEPTH (STORE),
        .WIDTH (WIDTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .cap     (cap),
        .wr_en   (wr_en),
        .wr_data (isr_data),
        .rd_en   (pop),
        .rd_data (bus.rd_data),
        .level   (bus.level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_pio_rx_fifo.sv
// Directed bench for pio_rx_fifo: queue-based reference model checked every
// cycle, plus hand-computed literal checks for each scenario.
module tb_pio_rx_fifo;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        penable = 1'b0;
    logic [31:0] isr_data = '0;
    logic [5:0]  isr_count = '0;
    logic        push_req = 1'b0;
    logic        push_iffull = 1'b0;
    logic        push_block = 1'b0;
    logic        autopush_en = 1'b0;
    logic [4:0]  push_thresh = '0;
    logic        isr_clear;
    logic        push_stall;
`ifdef PIO_RX_FIFO_JOIN_EN
    logic        fjoin_rx = 1'b0;
    bit          fjoin_prev;
`endif

    pio_rx_fifo_if bus_if ();

    pio_rx_fifo #(.DEPTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .penable     (penable),
        .isr_data    (isr_data),
        .isr_count   (isr_count),
        .push_req    (push_req),
        .push_iffull (push_iffull),
        .push_block  (push_block),
        .autopush_en (autopush_en),
        .push_thresh (push_thresh),
`ifdef PIO_RX_FIFO_JOIN_EN
        .fjoin_rx    (fjoin_rx),
`endif
        .isr_clear   (isr_clear),
        .push_stall  (push_stall),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mq[$];
    bit          m_stall_flag, m_under_flag;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int cap_m();
`ifdef PIO_RX_FIFO_JOIN_EN
        return fjoin_rx ? 8 : 4;
`else
        return 4;
`endif
    endfunction

    // What this cycle's push request must do, from the current inputs and model contents.
    function automatic void model_eval(output bit clr, output bit stall, output bit wr, output bit on_full);
        int thr;
        bit hit, ap, ep, pr, f;
        thr     = (push_thresh == 5'd0) ? 32 : int'(push_thresh);
        hit     = int'(isr_count) >= thr;
        ap      = penable && autopush_en && hit;
        ep      = penable && !ap && push_req && !(push_iffull && !hit);
        pr      = ap || ep;
        f       = mq.size() >= cap_m();
        wr      = pr && !f;
        stall   = pr && f && (ap || push_block);
        clr     = pr && !stall;
        on_full = pr && f;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        bit clr, st, wr, pf, pop, und;
        if (!reset_n) begin
            mq.delete();
            m_stall_flag = 1'b0;
            m_under_flag = 1'b0;
`ifdef PIO_RX_FIFO_JOIN_EN
            fjoin_prev = 1'b0;
`endif
        end else begin
            model_eval(clr, st, wr, pf);
            pop = bus_if.rd_ready && (mq.size() > 0);
            und = bus_if.rd_ready && (mq.size() == 0);
            if (pop) void'(mq.pop_front());
            if (wr) mq.push_back(isr_data);
`ifdef PIO_RX_FIFO_JOIN_EN
            if (fjoin_rx != fjoin_prev) mq.delete();
            fjoin_prev = fjoin_rx;
`endif
            if (bus_if.flag_clr[0]) m_stall_flag = 1'b0;
            else if (pf) m_stall_flag = 1'b1;
            if (bus_if.flag_clr[1]) m_under_flag = 1'b0;
            else if (und) m_under_flag = 1'b1;
            if (wr || pop || und)
                $display("t=%0t push=%0d data=%h pop=%0d under=%0d level=%0d",
                         $time, wr, isr_data, pop, und, mq.size());
        end
    end

    always @(negedge clk) begin
        bit clr, st, wr, pf;
        if (!reset_n) begin
            chk("rst_isr_clear", 32'(isr_clear), 32'd0);
            chk("rst_push_stall", 32'(push_stall), 32'd0);
            chk("rst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
            chk("rst_level", 32'(bus_if.level), 32'd0);
            chk("rst_rd_data", bus_if.rd_data, 32'd0);
            chk("rst_flags", 32'({bus_if.rx_under_flag, bus_if.rx_stall_flag}), 32'd0);
        end else begin
            model_eval(clr, st, wr, pf);
            chk("isr_clear", 32'(isr_clear), 32'(clr));
            chk("push_stall", 32'(push_stall), 32'(st));
            chk("rd_valid", 32'(bus_if.rd_valid), 32'(mq.size() != 0));
            chk("level", 32'(bus_if.level), 32'(mq.size()));
            chk("full", 32'(bus_if.full), 32'(mq.size() == cap_m()));
            chk("stall_flag", 32'(bus_if.rx_stall_flag), 32'(m_stall_flag));
            chk("under_flag", 32'(bus_if.rx_under_flag), 32'(m_under_flag));
            if (mq.size() != 0) chk("rd_data", bus_if.rd_data, mq[0]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        bus_if.rd_ready = 1'b0;
        bus_if.flag_clr = 2'b00;
        repeat (2) cyc();
        reset_n = 1'b1;
        cyc();

        // Autopush at threshold 8
        penable = 1'b1; autopush_en = 1'b1; push_thresh = 5'd8; isr_data = 32'hA5;
        for (int i = 0; i <= 8; i++) begin
            isr_count = 6'(i);
            at_neg();
            if (i == 7) chk("ap_below_thr", 32'(isr_clear), 32'd0);
            if (i == 8) chk("ap_clear", 32'(isr_clear), 32'd1);
            cyc();
        end
        isr_count = '0; autopush_en = 1'b0; bus_if.rd_ready = 1'b1;
        at_neg();
        chk("ap_valid", 32'(bus_if.rd_valid), 32'd1);
        chk("ap_data", bus_if.rd_data, 32'h0000_00A5);
        chk("ap_level", 32'(bus_if.level), 32'd1);
        cyc();
        bus_if.rd_ready = 1'b0;

        // Threshold 0 means 32
        autopush_en = 1'b1; push_thresh = 5'd0; isr_data = 32'h1234_5678; isr_count = 6'd31;
        at_neg(); chk("thr0_31", 32'(isr_clear), 32'd0); cyc();
        isr_count = 6'd32;
        at_neg(); chk("thr0_32", 32'(isr_clear), 32'd1); cyc();
        isr_count = '0; autopush_en = 1'b0;
        at_neg();
        chk("thr0_level", 32'(bus_if.level), 32'd1);
        chk("thr0_data", bus_if.rd_data, 32'h1234_5678);
        cyc();

        // IfFull PUSH
        push_thresh = 5'd16; push_req = 1'b1; push_iffull = 1'b1; isr_count = 6'd10; isr_data = 32'h00C0_FFEE;
        at_neg(); chk("iffull_miss", 32'(isr_clear), 32'd0); cyc();
        isr_count = 6'd16;
        at_neg(); chk("iffull_hit", 32'(isr_clear), 32'd1); cyc();
        push_iffull = 1'b0; isr_count = '0;

        // Fill to four entries
        isr_data = 32'h100; cyc();
        isr_data = 32'h101; cyc();
        push_req = 1'b0;
        at_neg();
        chk("fill_level", 32'(bus_if.level), 32'd4);
        chk("fill_full", 32'(bus_if.full), 32'd1);
        cyc();

        // Blocking PUSH on full
        push_req = 1'b1; push_block = 1'b1; isr_data = 32'h5;
        at_neg();
        chk("blk_stall", 32'(push_stall), 32'd1);
        chk("blk_noclear", 32'(isr_clear), 32'd0);
        cyc();
        at_neg();
        chk("blk_stall_held", 32'(push_stall), 32'd1);
        chk("blk_flag", 32'(bus_if.rx_stall_flag), 32'd1);
        cyc();
        bus_if.rd_ready = 1'b1;
        at_neg(); chk("blk_pop_cycle_stall", 32'(push_stall), 32'd1); cyc();
        bus_if.rd_ready = 1'b0;
        at_neg();
        chk("blk_release_clear", 32'(isr_clear), 32'd1);
        chk("blk_release_stall", 32'(push_stall), 32'd0);
        cyc();
        push_req = 1'b0; push_block = 1'b0;
        at_neg();
        chk("blk_level", 32'(bus_if.level), 32'd4);
        chk("blk_head", bus_if.rd_data, 32'h00C0_FFEE);
        cyc();

        // Non-blocking PUSH on full drops the data
        push_req = 1'b1; isr_data = 32'hDEAD;
        at_neg();
        chk("nb_clear", 32'(isr_clear), 32'd1);
        chk("nb_stall", 32'(push_stall), 32'd0);
        cyc();
        push_req = 1'b0; bus_if.flag_clr = 2'b01;
        at_neg();
        chk("nb_level", 32'(bus_if.level), 32'd4);
        chk("nb_head", bus_if.rd_data, 32'h00C0_FFEE);
        cyc();
        bus_if.flag_clr = 2'b00;
        at_neg(); chk("stall_flag_clr", 32'(bus_if.rx_stall_flag), 32'd0); cyc();

        // Drain, then pop once more on empty
        bus_if.rd_ready = 1'b1;
        repeat (4) cyc();
        at_neg(); chk("drain_empty", 32'(bus_if.rd_valid), 32'd0); cyc();
        bus_if.rd_ready = 1'b0;
        at_neg(); chk("under_set", 32'(bus_if.rx_under_flag), 32'd1); cyc();
        bus_if.flag_clr = 2'b10; cyc();
        bus_if.flag_clr = 2'b00;
        at_neg(); chk("under_clr", 32'(bus_if.rx_under_flag), 32'd0); cyc();

        // Simultaneous push and pop
        push_req = 1'b1; isr_data = 32'h77; cyc();
        isr_data = 32'h88; bus_if.rd_ready = 1'b1;
        at_neg(); chk("sim_pre_data", bus_if.rd_data, 32'h77); cyc();
        push_req = 1'b0; bus_if.rd_ready = 1'b0;
        at_neg();
        chk("sim_level", 32'(bus_if.level), 32'd1);
        chk("sim_data", bus_if.rd_data, 32'h88);
        cyc();

        // penable low blocks pushes
        penable = 1'b0; push_req = 1'b1; isr_data = 32'h99;
        at_neg(); chk("pen_low_clear", 32'(isr_clear), 32'd0); cyc();
        penable = 1'b1; push_req = 1'b0;
        at_neg(); chk("pen_low_level", 32'(bus_if.level), 32'd1); cyc();

        // Reset while stalled
        push_req = 1'b1;
        isr_data = 32'h90; cyc();
        isr_data = 32'h91; cyc();
        isr_data = 32'h92; cyc();
        push_block = 1'b1; isr_data = 32'hEE;
        at_neg(); chk("rst_pre_stall", 32'(push_stall), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstst_stall", 32'(push_stall), 32'd0);
        chk("rstst_clear", 32'(isr_clear), 32'd0);
        chk("rstst_valid", 32'(bus_if.rd_valid), 32'd0);
        chk("rstst_level", 32'(bus_if.level), 32'd0);
        chk("rstst_full", 32'(bus_if.full), 32'd0);
        chk("rstst_data", bus_if.rd_data, 32'd0);
        chk("rstst_flag", 32'(bus_if.rx_stall_flag), 32'd0);
        cyc();
        push_req = 1'b0; push_block = 1'b0;
        cyc();
        reset_n = 1'b1;
        at_neg(); chk("post_rst_level", 32'(bus_if.level), 32'd0); cyc();

`ifdef PIO_RX_FIFO_JOIN_EN
        fjoin_rx = 1'b1; cyc();
        push_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            isr_data = 32'h200 + 32'(i);
            cyc();
        end
        push_req = 1'b0;
        at_neg();
        chk("join_level", 32'(bus_if.level), 32'd8);
        chk("join_full", 32'(bus_if.full), 32'd1);
        cyc();
        fjoin_rx = 1'b0; cyc();
        at_neg(); chk("join_flush", 32'(bus_if.level), 32'd0); cyc();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pio_rx_fifo.md
Name: pio_rx_fifo

Overview:
- Per-state-machine RX path directly downstream of the PIO input shift register (ISR).
- Executes explicit PUSH instructions and threshold-driven autopush.
- Writes ISR contents into a small FIFO, tells the ISR when to clear, and stalls the state machine on a full FIFO.
- Bus side gives the host a valid/ready read port plus level, full/empty and sticky debug flags.

Parameters:
- DEPTH, 4, entries in normal mode; power of two, ≥2.
- WIDTH, 32, data width; equals the ISR width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- penable  in  1  state-machine enable; push/autopush evaluated only when high
- isr_data  in  32  ISR shift_reg (dout)
- isr_count  in  6  ISR shift_count, 0..32
- push_req  in  1  PUSH instruction in execute this cycle
- push_iffull  in  1  PUSH IfFull bit
- push_block  in  1  PUSH Block bit
- autopush_en  in  1  SHIFTCTRL autopush
- push_thresh  in  5  autopush threshold; 0 means 32
- isr_clear  out  1  one-cycle pulse: ISR loads 0 with count 0 (drives ISR set, din=0, bit_count=0)
- push_stall  out  1  state machine must stall this cycle
- rd_data  out  32  FIFO head
- rd_valid  out  1  FIFO non-empty
- rd_ready  in  1  host pop
- level  out  4  current occupancy
- full  out  1  level == capacity
- rx_stall_flag  out  1  sticky: a push stalled on full
- rx_under_flag  out  1  sticky: pop while empty
- flag_clr  in  2  write-1-to-clear {under, stall}

Behaviour:
- Reset, asynchronous with reset_n low:
  - All outputs 0; level 0; read/write pointers 0; flags 0.
  - A push stalled at reset is abandoned.
- Threshold: thr = (push_thresh==0) ? 32 : push_thresh; width is 6 bits. `thresh_hit` = isr_count ≥ thr.
- Push request (pr), evaluated only when penable:
  - Autopush: autopush_en && thresh_hit. Autopush has priority over an explicit PUSH in the same cycle, and counts as the single push for that cycle.
  - Explicit PUSH: push_req && !(push_iffull && !thresh_hit). A PUSH that fails its IfFull test is a no-op, with no clear and no stall.
- Full is evaluated on pre-pop occupancy. A simultaneous pop does not free a slot for that cycle's push.
- Push outcome:
  - pr && !full: write isr_data at wptr on the rising edge; level+1; isr_clear=1 in the same cycle; push_stall=0.
  - pr && full && (autopush or push_block): push_stall=1, isr_clear=0, rx_stall_flag set. Re-evaluated every cycle until space exists.
  - pr && full && explicit && !push_block: data dropped, isr_clear=1, no stall, rx_stall_flag set.
- Pop:
  - rd_ready && rd_valid: rptr advances, level−1.
  - rd_ready && !rd_valid: no state change, rx_under_flag set.
- Simultaneous push and pop, non-full: level unchanged, both pointers advance.
- Pointers wrap modulo capacity. level saturates logically at capacity; it can never exceed it.
- rd_data is registered from storage[rptr]. A write to an empty FIFO gives rd_valid=1 and valid rd_data on the next cycle (1-cycle latency).
- !penable: no pushes, push_stall=0, isr_clear=0. Bus pops still work.
- flag_clr takes priority over a set in the same cycle.
- Outcome state machine: IDLE, STALLED.
  - IDLE→STALLED on a blocking push with full.
  - STALLED→IDLE on a successful write, penable low, or reset.
  - STALLED only drives push_stall.

Optional Feature:
- Macro PIO_RX_FIFO_JOIN_EN.
- When defined:
  - Extra input port fjoin_rx (1 bit).
  - When high, capacity = 2*DEPTH and storage is 2*DEPTH entries.
  - Writing fjoin_rx flushes the FIFO (pointers and level to 0) on any change.
- When undefined: no port, capacity = DEPTH, storage DEPTH entries.
- level stays 4 bits in both builds.

Decomposition:
- Package pio_pkg holds:
  - WIDTH;
  - threshold decode function (5-bit→6-bit, 0→32);
  - push-outcome enum {PUSH_NONE, PUSH_WRITE, PUSH_STALL, PUSH_DROP};
  - state enum {IDLE, STALLED}.
- One sub-module pio_sync_fifo holds storage, pointers, level and full/empty. It is reused by the TX side.
- pio_rx_fifo keeps push arbitration, stall and flags.

Test Plan:
- Autopush: autopush_en=1, push_thresh=8, isr_count steps 0→8 with isr_data=0xA5 → isr_clear pulse that cycle; next cycle rd_valid=1, rd_data=0x000000A5, level=1.
- Threshold 0: push_thresh=0, isr_count=31 → no push; isr_count=32 → push, isr_clear=1.
- Blocking on full: fill 4 entries, PUSH block=1 with data 0x5 → push_stall held and rx_stall_flag=1. Then pop one → in the cycle after the pop, write occurs, isr_clear=1, stall drops, level=4.
- Noblock on full: full FIFO, PUSH block=0 → no stall, isr_clear=1, level stays 4, head unchanged.
- IfFull: push_iffull=1, thr=16, isr_count=10 → no write, no clear. With isr_count=16 → write.
- Edge cases:
  - Pop on empty → rx_under_flag=1; flag_clr=2'b10 → cleared.
  - reset_n low while STALLED → all outputs 0 immediately.
  - With PIO_RX_FIFO_JOIN_EN, fjoin_rx=1 → 8 writes accepted, full=1 at level 8.
